// File: rtl/ksa_pkg.sv
// ----------------------------------------------------------------------------
// ksa_pkg
// Shared definitions for the digit-serial Kogge-Stone subtractor.
//   DIGIT_W        default digit width in bits (power of two, >= 2)
//   PREFIX_LEVELS  number of Kogge-Stone prefix levels for DIGIT_W
//   prefix_levels  prefix level count for an arbitrary digit width
//   frame_state_t  framing state of the serial subtractor
// ----------------------------------------------------------------------------
package ksa_pkg;

  localparam int DIGIT_W       = 4;
  localparam int PREFIX_LEVELS = $clog2(DIGIT_W);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

  function automatic int prefix_levels(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/ksa_core.sv
// ----------------------------------------------------------------------------
// ksa_core
// Combinational W-bit Kogge-Stone adder: {cout, s} = a + b + cin.
//   a, b  in   W  addends
//   cin   in   1  carry into bit 0
//   s     out  W  sum
//   cout  out  1  carry out of bit W-1
// ----------------------------------------------------------------------------
module ksa_core
  import ksa_pkg::*;
#(
  parameter int W = DIGIT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int LV = prefix_levels(W);

  logic [W-1:0] g_init;
  logic [W-1:0] p_init;
  logic [W-1:0] g_all;
  logic [W-1:0] p_all;
  logic [W-1:0] c;

  assign g_init = a & b;
  assign p_init = a ^ b;

  // Each level combines every bit with the group DIST positions below it.
  // Bits below DIST have no partner: generate passes through unchanged, and
  // propagate is ANDed with ones so it also passes through.
  for (genvar gl = 0; gl < LV; gl++) begin : g_level
    localparam int DIST = 1 << gl;
    localparam logic [W-1:0] FILL = {W{1'b1}} >> (W - DIST);

    logic [W-1:0] g_prev;
    logic [W-1:0] p_prev;
    logic [W-1:0] g;
    logic [W-1:0] p;

    if (gl == 0) begin : g_src
      assign g_prev = g_init;
      assign p_prev = p_init;
    end else begin : g_src
      assign g_prev = g_level[gl-1].g;
      assign p_prev = g_level[gl-1].p;
    end

    assign g = g_prev | (p_prev & (g_prev << DIST));
    assign p = p_prev & ((p_prev << DIST) | FILL);
  end

  assign g_all = g_level[LV-1].g;
  assign p_all = g_level[LV-1].p;

  // g_all/p_all span bits [i:0]; folding in cin gives the carry out of bit i.
  assign c    = g_all | (p_all & {W{cin}});
  assign s    = p_init ^ {c[W-2:0], cin};
  assign cout = c[W-1];

endmodule

// File: rtl/ksa_serial_sub.sv
// ----------------------------------------------------------------------------
// ksa_serial_sub
// Digit-serial multi-precision subtractor, A - B, least-significant digit
// first. Each digit is A + ~B + cin through a Kogge-Stone adder; the borrow
// chain is carried between beats in carry_q. One-cycle registered output.
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   in_a, in_b             minuend / subtrahend digits (W bits)
//   in_first, in_last      frame delimiters
//   out_valid / out_ready  output handshake
//   out_d                  difference digit
//   out_last               last digit of the frame
//   out_borrow             A < B (only on out_last, else 0)
//   out_zero               whole difference is zero (only on out_last, else 0)
//   err_proto              one-cycle pulse after a beat with bad framing
// ----------------------------------------------------------------------------
module ksa_serial_sub
  import ksa_pkg::*;
#(
  parameter int W = DIGIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_d,
  output logic         out_last,
  output logic         out_borrow,
  output logic         out_zero,
  output logic         err_proto
);

  frame_state_t frame_state;
  logic         carry_q;
  logic         zacc_q;

  logic         accept;
  logic         starts;
  logic         cin;
  logic         zacc_in;
  logic         frame_err;
  logic         digit_zero;
  logic         zacc_next;
  logic [W-1:0] sum;
  logic         cout;

  // The output register can always take a new beat once its current beat
  // is leaving, so full throughput needs no extra buffering.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A missing in_first after a completed frame still starts a new frame, and
  // an unexpected in_first mid-frame restarts it; both are flagged.
  assign starts    = in_first || (frame_state == IDLE);
  assign frame_err = (frame_state == IN_FRAME) ? in_first : !in_first;

  // Subtraction as A + ~B + 1 on the first digit; afterwards the carry out
  // (the inverted borrow) feeds the next digit.
  assign cin     = starts ? 1'b1 : carry_q;
  assign zacc_in = starts ? 1'b1 : zacc_q;

  ksa_core #(
    .W (W)
  ) u_core (
    .a    (in_a),
    .b    (~in_b),
    .cin  (cin),
    .s    (sum),
    .cout (cout)
  );

  assign digit_zero = (sum == '0);
  assign zacc_next  = zacc_in & digit_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state <= IDLE;
      carry_q     <= 1'b1;
      zacc_q      <= 1'b1;
      out_valid   <= 1'b0;
      out_d       <= '0;
      out_last    <= 1'b0;
      out_borrow  <= 1'b0;
      out_zero    <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      err_proto <= accept && frame_err;

      if (accept) begin
        out_valid <= 1'b1;
        out_d     <= sum;
        out_last  <= in_last;
        if (in_last) begin
          frame_state <= IDLE;
          carry_q     <= 1'b1;
          zacc_q      <= 1'b1;
          out_borrow  <= ~cout;
          out_zero    <= zacc_next;
        end else begin
          frame_state <= IN_FRAME;
          carry_q     <= cout;
          zacc_q      <= zacc_next;
          out_borrow  <= 1'b0;
          out_zero    <= 1'b0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
